// File: rtl/approx_mul_err_monitor.sv
// Error monitor for an approximate multiplier: compares approx_prod against the
// exact a*b over a run of num_samples accepted samples and accumulates error stats.
module approx_mul_err_monitor #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic [2*W-1:0]       approx_prod,
    output logic                 busy,
    output logic                 done,
    output logic [2*W+CNT_W-1:0] sum_abs_err,
    output logic [2*W-1:0]       max_abs_err,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     over_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2*W-1:0]   exact;
    logic [2*W-1:0]   abs_err;
    logic             over;
    logic             accept;

    assign exact   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    assign over    = approx_prod > exact;
    assign abs_err = over ? (approx_prod - exact) : (exact - approx_prod);
    assign accept  = in_valid && (state == RUN);
    assign cnt_nxt = cnt + 1'b1;

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign in_ready = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            n_lat       <= '0;
            cnt         <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            err_count   <= '0;
            over_count  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        n_lat       <= num_samples;
                        cnt         <= '0;
                        sum_abs_err <= '0;
                        max_abs_err <= '0;
                        err_count   <= '0;
                        over_count  <= '0;
                        // An empty run has nothing to measure; report immediately.
                        state       <= (num_samples == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        sum_abs_err <= sum_abs_err + {{CNT_W{1'b0}}, abs_err};
                        if (abs_err > max_abs_err)
                            max_abs_err <= abs_err;
                        if (abs_err != '0)
                            err_count <= err_count + 1'b1;
                        if (over)
                            over_count <= over_count + 1'b1;
                        cnt <= cnt_nxt;
                        if (cnt_nxt == n_lat)
                            state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Self-checking bench for approx_mul_err_monitor: table vectors, directed
// corner-case sequences and randomized runs against an arithmetic model.
module tb_approx_mul_err_monitor;
    localparam int W     = 8;
    localparam int CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [CNT_W-1:0]     num_samples;
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         a;
    logic [W-1:0]         b;
    logic [2*W-1:0]       approx_prod;
    logic                 busy;
    logic                 done;
    logic [2*W+CNT_W-1:0] sum_abs_err;
    logic [2*W-1:0]       max_abs_err;
    logic [CNT_W-1:0]     err_count;
    logic [CNT_W-1:0]     over_count;

    approx_mul_err_monitor #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .approx_prod(approx_prod), .busy(busy), .done(done),
        .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err),
        .err_count(err_count), .over_count(over_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    longint m_sum, m_max, m_err, m_over;

    typedef struct {
        int a;
        int b;
        int p;
        int exp_err;
        int exp_over;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_run(input int n);
        num_samples = CNT_W'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input string name, input int x, input int y, input int p);
        chk({name, "_ready"}, 64'(in_ready), 64'd1);
        a = W'(x);
        b = W'(y);
        approx_prod = (2*W)'(p);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_res(input string name, input longint s, input longint m,
                             input longint e, input longint o);
        chk({name, "_sum"},  64'(sum_abs_err), 64'(s));
        chk({name, "_max"},  64'(max_abs_err), 64'(m));
        chk({name, "_errc"}, 64'(err_count),   64'(e));
        chk({name, "_over"}, 64'(over_count),  64'(o));
    endtask

    task automatic model_clear();
        m_sum = 0; m_max = 0; m_err = 0; m_over = 0;
    endtask

    task automatic model_add(input int x, input int y, input int p);
        longint ex, e;
        ex = longint'(x) * longint'(y);
        e  = longint'(p) - ex;
        if (e < 0) e = -e;
        m_sum += e;
        if (e > m_max) m_max = e;
        if (e != 0) m_err++;
        if (longint'(p) > ex) m_over++;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0,   0,   0,     0,     0};
        vecs[1] = '{255, 255, 0,     65025, 0};
        vecs[2] = '{0,   0,   65535, 65535, 1};
        vecs[3] = '{1,   1,   1,     0,     0};
        vecs[4] = '{16,  16,  255,   1,     0};
        vecs[5] = '{200, 3,   650,   50,    1};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        num_samples = '0; a = '0; b = '0; approx_prod = '0;
        step(); step();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_ready", 64'(in_ready), 0);
        check_res("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", 64'(busy), 0);
        chk("post_rst_done", 64'(done), 0);

        // Basic run
        start_run(3);
        chk("basic_busy", 64'(busy), 1);
        send("basic0", 3, 5, 15);
        send("basic1", 10, 10, 96);
        chk("basic_mid_done", 64'(done), 0);
        send("basic2", 255, 255, 65000);
        chk("basic_done", 64'(done), 1);
        chk("basic_ready_off", 64'(in_ready), 0);
        check_res("basic", 29, 25, 2, 0);
        in_valid = 1'b1; a = 8'd7; b = 8'd7; approx_prod = 16'd0;
        step();
        in_valid = 1'b0;
        check_res("done_hold", 29, 25, 2, 0);

        // Restart from DONE, then overestimate sample
        start_run(1);
        chk("restart_busy", 64'(busy), 1);
        chk("restart_done", 64'(done), 0);
        check_res("restart", 0, 0, 0, 0);
        send("overest", 2, 2, 7);
        chk("overest_done", 64'(done), 1);
        check_res("overest", 3, 3, 1, 1);

        // Zero-sample run
        start_run(0);
        chk("zero_done", 64'(done), 1);
        chk("zero_ready", 64'(in_ready), 0);
        chk("zero_busy", 64'(busy), 0);
        check_res("zero", 0, 0, 0, 0);

        // Table of single-sample runs
        foreach (vecs[i]) begin
            start_run(1);
            send($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
            chk($sformatf("vec%0d_done", i), 64'(done), 1);
            check_res($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_err,
                      (vecs[i].exp_err != 0) ? 1 : 0, vecs[i].exp_over);
        end

        // Backpressure gaps with a mid-run start that must be ignored
        start_run(2);
        in_valid = 1'b0; a = 8'd99; b = 8'd99; approx_prod = 16'd0;
        step();
        num_samples = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        send("gap0", 12, 12, 140);
        step(); step();
        send("gap1", 9, 9, 90);
        chk("gap_done", 64'(done), 1);
        chk("gap_ready", 64'(in_ready), 0);
        check_res("gap", 13, 9, 2, 1);

        // Reset arriving mid-run
        start_run(3);
        send("mid0", 3, 4, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_done", 64'(done), 0);
        chk("midrst_ready", 64'(in_ready), 0);
        check_res("midrst", 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("midrst_idle", 64'(busy), 0);
        start_run(1);
        send("after_rst", 4, 4, 16);
        chk("after_rst_done", 64'(done), 1);
        check_res("after_rst", 0, 0, 0, 0);

        // Randomized runs against the model
        for (int r = 0; r < 25; r++) begin
            int n, acc, cyc;
            n = $urandom_range(1, 8);
            start_run(n);
            model_clear();
            acc = 0; cyc = 0;
            while (acc < n && cyc < 200) begin
                int x, y, ex, d, p;
                x = $urandom_range(0, 255);
                y = $urandom_range(0, 255);
                ex = x * y;
                d = $urandom_range(0, 40);
                case ($urandom_range(0, 3))
                    0: p = ex;
                    1: p = (ex + d > 65535) ? 65535 : ex + d;
                    2: p = (ex >= d) ? ex - d : 0;
                    default: p = $urandom_range(0, 65535);
                endcase
                a = W'(x); b = W'(y); approx_prod = (2*W)'(p);
                in_valid = ($urandom_range(0, 2) != 0);
                start = ($urandom_range(0, 7) == 0);
                num_samples = CNT_W'($urandom_range(0, 20));
                if (in_valid && in_ready) begin
                    model_add(x, y, p);
                    acc++;
                end
                step();
                cyc++;
            end
            in_valid = 1'b0;
            start = 1'b0;
            if (cyc >= 200)
                chk($sformatf("rnd%0d_timeout", r), 64'(acc), 64'(n));
            chk($sformatf("rnd%0d_done", r), 64'(done), 1);
            check_res($sformatf("rnd%0d", r), m_sum, m_max, m_err, m_over);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
